// File: rtl/simt_icache_if.sv
// Fetch-side and memory-side bus of the SIMT instruction cache.
// imemREN is a level request answered combinationally; a memory word is accepted in any cycle with iREN=1 and iwait=0.
interface simt_icache_if #(
  parameter int WORD_W = 32
);
  logic              imemREN;
  logic [WORD_W-1:0] imemaddr;
  logic              iflush;
  logic              icacheHit;
  logic [WORD_W-1:0] imemload;
  logic              iREN;
  logic [WORD_W-1:0] iaddr;
  logic              iwait;
  logic [WORD_W-1:0] iload;
  logic [WORD_W-1:0] miss_count;

  modport slave (
    input  imemREN, imemaddr, iflush, iwait, iload,
    output icacheHit, imemload, iREN, iaddr, miss_count
  );

  modport master (
    output imemREN, imemaddr, iflush, iwait, iload,
    input  icacheHit, imemload, iREN, iaddr, miss_count
  );
endinterface

// File: rtl/simt_icache.sv
// Direct-mapped instruction cache: zero-latency hits, in-order block fill on miss,
// whole-array flush (deferred to fill end while a fill is running) and a wrapping miss counter.
module simt_icache #(
  parameter int WORD_W   = 32,
  parameter int NSETS    = 16,
  parameter int BLKWORDS = 2
) (
  input  logic          CLK,
  input  logic          nRST,
  simt_icache_if.slave  bus,
  output logic          dbg_fill
);
  localparam int OB = $clog2(BLKWORDS);
  localparam int IB = $clog2(NSETS);
  localparam int KW = (OB > 0) ? OB : 1;
  localparam int TW = WORD_W - 2 - OB - IB;
  localparam logic [KW-1:0] K_LAST = KW'(BLKWORDS - 1);

  typedef enum logic {IDLE, FILL} state_t;

  state_t            state_q, state_d;
  logic [NSETS-1:0]  valid_q, valid_d;
  logic [TW-1:0]     tag_q  [NSETS];
  logic [TW-1:0]     tag_d  [NSETS];
  logic [WORD_W-1:0] data_q [NSETS][BLKWORDS];
  logic [WORD_W-1:0] data_d [NSETS][BLKWORDS];
  logic [TW-1:0]     ftag_q, ftag_d;
  logic [IB-1:0]     fidx_q, fidx_d;
  logic [KW-1:0]     k_q, k_d;
  logic              flush_pend_q, flush_pend_d;
  logic [WORD_W-1:0] miss_q, miss_d;

  logic [IB-1:0]     req_idx;
  logic [TW-1:0]     req_tag;
  logic [KW-1:0]     req_woff_raw;
  logic [KW-1:0]     req_woff;
  logic              hit;
  logic [WORD_W-1:0] fill_addr;

  assign req_idx      = bus.imemaddr[2+OB +: IB];
  assign req_tag      = bus.imemaddr[WORD_W-1 -: TW];
  assign req_woff_raw = bus.imemaddr[2 +: KW];
  // With one word per line there is no word-offset field; bit 2 belongs to the index.
  assign req_woff     = (OB == 0) ? '0 : req_woff_raw;
  assign hit          = bus.imemREN && valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign dbg_fill     = (state_q == FILL);
  assign bus.miss_count = miss_q;

  // Index and tag are written after k so they win over bit 2 when OB is 0.
  always_comb begin
    fill_addr                  = '0;
    fill_addr[2 +: KW]         = k_q;
    fill_addr[2+OB +: IB]      = fidx_q;
    fill_addr[WORD_W-1 -: TW]  = ftag_q;
  end

  always_comb begin
    state_d       = state_q;
    valid_d       = valid_q;
    tag_d         = tag_q;
    data_d        = data_q;
    ftag_d        = ftag_q;
    fidx_d        = fidx_q;
    k_d           = k_q;
    flush_pend_d  = flush_pend_q;
    miss_d        = miss_q;
    bus.icacheHit = 1'b0;
    bus.imemload  = '0;
    bus.iREN      = 1'b0;
    bus.iaddr     = '0;
    unique case (state_q)
      IDLE: begin
        bus.icacheHit = hit;
        if (hit) bus.imemload = data_q[req_idx][req_woff];
        if (bus.iflush) valid_d = '0;
        if (bus.imemREN && !hit) begin
          ftag_d       = req_tag;
          fidx_d       = req_idx;
          k_d          = '0;
          flush_pend_d = 1'b0;
          miss_d       = miss_q + 1'b1;
          state_d      = FILL;
        end
      end
      FILL: begin
        bus.iREN  = 1'b1;
        bus.iaddr = fill_addr;
        if (bus.iflush) flush_pend_d = 1'b1;
        if (!bus.iwait) begin
          data_d[fidx_q][k_q] = bus.iload;
          if (k_q == K_LAST) begin
            // A flush seen at any point of the fill, including this last cycle, drops the line.
            if (flush_pend_q || bus.iflush) begin
              valid_d = '0;
            end else begin
              tag_d[fidx_q]   = ftag_q;
              valid_d[fidx_q] = 1'b1;
            end
            flush_pend_d = 1'b0;
            k_d          = '0;
            state_d      = IDLE;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      k_q          <= '0;
      flush_pend_q <= 1'b0;
      miss_q       <= '0;
      ftag_q       <= '0;
      fidx_q       <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      k_q          <= k_d;
      flush_pend_q <= flush_pend_d;
      miss_q       <= miss_d;
      ftag_q       <= ftag_d;
      fidx_q       <= fidx_d;
    end
  end

  // Tag and data arrays are only meaningful under a set valid bit, so they carry no reset.
  always_ff @(posedge CLK) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end
endmodule

// File: tb/tb_simt_icache.sv
// Self-checking bench for simt_icache: directed vector table, hand-written reset/fill
// sequences and randomized fetches checked against an address-arithmetic cache model.
module tb_simt_icache;
  localparam int NSETS = 16;
  localparam int BLK   = 2;

  logic CLK;
  logic nRST;
  logic dbg_fill;
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   wait_per_word = 0;
  int   wcnt = 0;

  simt_icache_if #(.WORD_W(32)) bus ();

  simt_icache #(.WORD_W(32), .NSETS(NSETS), .BLKWORDS(BLK)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .bus      (bus),
    .dbg_fill (dbg_fill)
  );

  // Clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory model: fixed content per word address, programmable wait cycles per word.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign bus.iload = mem_fn(bus.iaddr);
  assign bus.iwait = bus.iREN && (wcnt < wait_per_word);

  always @(posedge CLK) begin
    if (!bus.iREN || !bus.iwait) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  // Reference model: which tag each set holds, and the miss count.
  bit          model_valid [NSETS];
  int          model_tag   [NSETS];
  logic [31:0] mc_model;

  function automatic bit model_hit(input logic [31:0] a);
    int idx, tg;
    idx = int'((a / (4 * BLK)) % NSETS);
    tg  = int'(a / (4 * BLK * NSETS));
    return model_valid[idx] && (model_tag[idx] == tg);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NSETS; i++) model_valid[i] = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver: one fetch, entered and left at posedge+1.
  task automatic fetch(input logic [31:0] addr, input int wpw, input bit exp_hit,
                       input bit flush_now, input bit flush_mid, input bit drop_mid,
                       input logic [31:0] exp_mc);
    int          idx, tg, cycles, k;
    bit          acc, held;
    logic [31:0] base;
    idx  = int'((addr / (4 * BLK)) % NSETS);
    tg   = int'(addr / (4 * BLK * NSETS));
    base = addr & ~32'(4 * BLK - 1);
    held = !(flush_mid || drop_mid);
    wait_per_word = wpw;
    bus.imemREN  = 1'b1;
    bus.imemaddr = addr;
    bus.iflush   = flush_now;
    #1;
    check("hit", 32'(bus.icacheHit), 32'(exp_hit));
    check("load", bus.imemload, exp_hit ? mem_fn(addr & ~32'h3) : 32'h0);
    check("iren_idle", 32'(bus.iREN), 32'h0);
    @(posedge CLK); #1;
    bus.iflush = 1'b0;
    if (flush_now) model_clear();
    if (!exp_hit) begin
      mc_model = mc_model + 1;
      cycles = 0;
      k = 0;
      while (bus.iREN === 1'b1 && cycles < 200) begin
        check("iaddr", bus.iaddr, base + 32'(4 * k));
        check("hit_in_fill", 32'(bus.icacheHit), 32'h0);
        if (cycles == 1 && !held) begin
          bus.imemREN = 1'b0;
          bus.iflush  = flush_mid;
        end
        acc = !bus.iwait;
        @(posedge CLK); #1;
        bus.iflush = 1'b0;
        if (acc) k++;
        cycles++;
      end
      check("fill_len", 32'(cycles), 32'(BLK * (1 + wpw)));
      if (flush_mid) begin
        model_clear();
      end else begin
        model_valid[idx] = 1'b1;
        model_tag[idx]   = tg;
      end
      if (held) begin
        check("hit_after_fill", 32'(bus.icacheHit), 32'h1);
        check("load_after_fill", bus.imemload, mem_fn(addr & ~32'h3));
      end
    end
    check("miss_count", bus.miss_count, exp_mc);
    bus.imemREN = 1'b0;
  endtask

  typedef struct {
    logic [31:0] addr;
    int          wpw;
    bit          flush_now;
    bit          flush_mid;
    bit          drop_mid;
    bit          exp_hit;
    logic [31:0] exp_mc;
  } vec_t;

  vec_t vecs [14];

  initial begin
    logic [31:0] a;
    bit          h, fl, flm;
    int          w;

    vecs[0]  = '{32'h0000_0040, 0, 0, 0, 0, 0, 32'd1};  // cold fetch
    vecs[1]  = '{32'h0000_0044, 0, 0, 0, 0, 1, 32'd1};  // spatial hit
    vecs[2]  = '{32'h0000_00C0, 0, 0, 0, 0, 0, 32'd2};  // conflict
    vecs[3]  = '{32'h0000_0040, 0, 0, 0, 0, 0, 32'd3};
    vecs[4]  = '{32'h0000_0080, 3, 0, 0, 1, 0, 32'd4};  // waits, request dropped
    vecs[5]  = '{32'h0000_0084, 0, 0, 0, 0, 1, 32'd4};
    vecs[6]  = '{32'h0000_0040, 0, 1, 0, 0, 1, 32'd4};  // hit with idle flush
    vecs[7]  = '{32'h0000_0040, 0, 0, 0, 0, 0, 32'd5};
    vecs[8]  = '{32'h0000_0100, 1, 0, 1, 0, 0, 32'd6};  // flush mid-fill
    vecs[9]  = '{32'h0000_0100, 0, 0, 0, 0, 0, 32'd7};
    vecs[10] = '{32'h0000_0104, 0, 0, 0, 0, 1, 32'd7};
    vecs[11] = '{32'h0000_0084, 0, 1, 0, 0, 0, 32'd8};  // miss with idle flush
    vecs[12] = '{32'h0000_0080, 0, 0, 0, 0, 1, 32'd8};
    vecs[13] = '{32'h0000_0040, 0, 0, 0, 0, 0, 32'd9};

    bus.imemREN  = 1'b0;
    bus.imemaddr = '0;
    bus.iflush   = 1'b0;
    nRST         = 1'b0;
    model_clear();
    mc_model = '0;
    #1;
    check("rst_hit", 32'(bus.icacheHit), 32'h0);
    check("rst_iren", 32'(bus.iREN), 32'h0);
    check("rst_iaddr", bus.iaddr, 32'h0);
    check("rst_load", bus.imemload, 32'h0);
    check("rst_miss_count", bus.miss_count, 32'h0);
    check("rst_state", 32'(dbg_fill), 32'h0);
    repeat (2) @(posedge CLK);
    #1;
    nRST = 1'b1;

    for (int i = 0; i < 14; i++)
      fetch(vecs[i].addr, vecs[i].wpw, vecs[i].exp_hit, vecs[i].flush_now,
            vecs[i].flush_mid, vecs[i].drop_mid, vecs[i].exp_mc);

    // Asynchronous reset in the middle of a fill.
    wait_per_word = 2;
    bus.imemREN   = 1'b1;
    bus.imemaddr  = 32'h0000_0200;
    #1;
    check("pre_rst_hit", 32'(bus.icacheHit), 32'h0);
    @(posedge CLK); #1;
    check("pre_rst_iren", 32'(bus.iREN), 32'h1);
    check("pre_rst_state", 32'(dbg_fill), 32'h1);
    bus.imemREN = 1'b0;
    #1;
    nRST = 1'b0;
    #1;
    check("midrst_iren", 32'(bus.iREN), 32'h0);
    check("midrst_iaddr", bus.iaddr, 32'h0);
    check("midrst_hit", 32'(bus.icacheHit), 32'h0);
    check("midrst_load", bus.imemload, 32'h0);
    check("midrst_miss_count", bus.miss_count, 32'h0);
    check("midrst_state", 32'(dbg_fill), 32'h0);
    @(posedge CLK); #1;
    nRST = 1'b1;
    model_clear();
    mc_model = '0;
    fetch(32'h0000_0200, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd1);
    fetch(32'h0000_0044, 1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd2);

    // Randomized fetches against the model.
    for (int n = 0; n < 250; n++) begin
      a   = 32'($urandom_range(0, 95)) * 32'd4;
      w   = int'($urandom_range(0, 2));
      h   = model_hit(a);
      fl  = ($urandom_range(0, 7) == 0);
      flm = !h && ($urandom_range(0, 5) == 0);
      fetch(a, w, h, fl, flm, 1'b0, mc_model + (h ? 32'd0 : 32'd1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
